// File: rtl/mul_div_sequencer.sv
// Multi-cycle unsigned 32x32 MULTU/DIVU sequencer that borrows the shared ALU for one add/sub per clock.
// Latency DATA_W+1 cycles from start to done (1 for divide-by-zero); start is ignored while busy_o is high.
module mul_div_sequencer #(
  parameter int         DATA_W  = 32,
  parameter logic [3:0] ALU_ADD = 4'd2,
  parameter logic [3:0] ALU_SUB = 4'd6,
  parameter logic [3:0] ALU_NOP = 4'd0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              op_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic [DATA_W-1:0] alu_src1_o,
  output logic [DATA_W-1:0] alu_src2_o,
  output logic [3:0]        alu_ctrl_o,
  input  logic [DATA_W-1:0] alu_result_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              op_q, op_nxt;
  logic [DATA_W-1:0] opnd_q, opnd_nxt;
  logic [DATA_W-1:0] hi_q, hi_nxt;
  logic [DATA_W-1:0] lo_q, lo_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] sh;
  logic              carry;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      op_q   <= 1'b0;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
    end else begin
      state  <= state_nxt;
      op_q   <= op_nxt;
      opnd_q <= opnd_nxt;
      hi_q   <= hi_nxt;
      lo_q   <= lo_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    op_nxt     = op_q;
    opnd_nxt   = opnd_q;
    hi_nxt     = hi_q;
    lo_nxt     = lo_q;
    cnt_nxt    = cnt_q;
    sum        = '0;
    sh         = '0;
    carry      = 1'b0;
    alu_src1_o = '0;
    alu_src2_o = '0;
    alu_ctrl_o = ALU_NOP;

    case (state)
      IDLE: begin
        if (start_i) begin
          op_nxt  = op_i;
          cnt_nxt = '0;
          if (op_i && (src2_i == '0)) begin
            hi_nxt    = src1_i;
            lo_nxt    = '1;
            state_nxt = DONE;
          end else begin
            // opnd holds the multiplicand for MULTU, the divisor for DIVU
            opnd_nxt  = op_i ? src2_i : src1_i;
            hi_nxt    = '0;
            lo_nxt    = op_i ? src1_i : src2_i;
            state_nxt = CALC;
          end
        end
      end

      CALC: begin
        cnt_nxt = cnt_q + 1'b1;
        if (!op_q) begin
          alu_src1_o = hi_q;
          alu_src2_o = opnd_q;
          alu_ctrl_o = ALU_ADD;
          if (lo_q[0]) begin
            sum   = alu_result_i;
            carry = (alu_result_i < hi_q);
          end else begin
            sum   = hi_q;
            carry = 1'b0;
          end
          {hi_nxt, lo_nxt} = {carry, sum, lo_q[DATA_W-1:1]};
        end else begin
          sh         = {hi_q[DATA_W-2:0], lo_q[DATA_W-1]};
          alu_src1_o = sh;
          alu_src2_o = opnd_q;
          alu_ctrl_o = ALU_SUB;
          // a set msb means the shifted remainder is 33 bits wide and always covers the divisor
          if (hi_q[DATA_W-1] || (sh >= opnd_q)) begin
            hi_nxt = alu_result_i;
            lo_nxt = {lo_q[DATA_W-2:0], 1'b1};
          end else begin
            hi_nxt = sh;
            lo_nxt = {lo_q[DATA_W-2:0], 1'b0};
          end
        end
        if (cnt_q == CNT_LAST) begin
          state_nxt = DONE;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy_o = (state != IDLE);
  assign done_o = (state == DONE);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Randomized scoreboard bench for mul_div_sequencer with an external ALU model.
module tb_mul_div_sequencer;

  localparam int DATA_W = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic              op_i;
  logic [DATA_W-1:0] src1_i;
  logic [DATA_W-1:0] src2_i;
  logic [DATA_W-1:0] alu_src1_o;
  logic [DATA_W-1:0] alu_src2_o;
  logic [3:0]        alu_ctrl_o;
  logic [DATA_W-1:0] alu_result_i;
  logic              busy_o;
  logic              done_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  mul_div_sequencer dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .op_i         (op_i),
    .src1_i       (src1_i),
    .src2_i       (src2_i),
    .alu_src1_o   (alu_src1_o),
    .alu_src2_o   (alu_src2_o),
    .alu_ctrl_o   (alu_ctrl_o),
    .alu_result_i (alu_result_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  always #5 clk_i = ~clk_i;

  // Shared single-cycle ALU: add, sub, otherwise and
  assign alu_result_i = (alu_ctrl_o == 4'd2) ? (alu_src1_o + alu_src2_o) :
                        (alu_ctrl_o == 4'd6) ? (alu_src1_o - alu_src2_o) :
                                               (alu_src1_o & alu_src2_o);

  typedef struct {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    int                acc;
    int                lat;
  } exp_t;

  exp_t q[$];
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 0;

  always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input bit op, input logic [31:0] a, input logic [31:0] b, input int acc);
    exp_t        e;
    logic [63:0] p;
    e.acc = acc;
    if (!op) begin
      p     = {32'd0, a} * {32'd0, b};
      e.hi  = p[63:32];
      e.lo  = p[31:0];
      e.lat = DATA_W;
    end else if (b == 0) begin
      e.hi  = a;
      e.lo  = 32'hFFFF_FFFF;
      e.lat = 0;
    end else begin
      e.hi  = a % b;
      e.lo  = a / b;
      e.lat = DATA_W;
    end
    return e;
  endfunction

  // Monitor: busy window, idle ALU outputs, done timing and results against the queue head
  always @(negedge clk_i) begin : monitor
    int e;
    bit bexp, dexp;
    if (mon_en) begin
      e    = edge_cnt;
      bexp = 0;
      dexp = 0;
      if (q.size() > 0) begin
        bexp = (e >= q[0].acc) && (e <= q[0].acc + q[0].lat);
        dexp = (e == q[0].acc + q[0].lat);
      end
      chk("busy", 64'(busy_o), 64'(bexp));
      if (!bexp) begin
        chk("idle_alu_ctrl", 64'(alu_ctrl_o), 64'd0);
        chk("idle_alu_src", {alu_src1_o, alu_src2_o}, 64'd0);
      end
      if (done_o || dexp) begin
        chk("done", 64'(done_o), 64'(dexp));
        if (dexp) begin
          chk("hi", 64'(hi_o), 64'(q[0].hi));
          chk("lo", 64'(lo_o), 64'(q[0].lo));
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic issue(input bit op, input logic [31:0] a, input logic [31:0] b, output int acc);
    @(negedge clk_i);
    start_i = 1'b1;
    op_i    = op;
    src1_i  = a;
    src2_i  = b;
    acc     = edge_cnt + 1;
    q.push_back(model(op, a, b, acc));
    @(negedge clk_i);
    start_i = 1'b0;
    op_i    = 1'($urandom);
    src1_i  = $urandom;
    src2_i  = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk_i);
    if (q.size() > 0) begin
      chk("done_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  task automatic run(input bit op, input logic [31:0] a, input logic [31:0] b);
    int acc;
    issue(op, a, b, acc);
    wait_idle();
  endtask

  initial begin : driver
    int          acc;
    int          sel;
    bit          rop;
    logic [31:0] ra, rb;

    rst_i   = 1'b1;
    start_i = 1'b0;
    op_i    = 1'b0;
    src1_i  = '0;
    src2_i  = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    chk("rst_alu_ctrl", 64'(alu_ctrl_o), 64'd0);
    chk("rst_alu_src", {alu_src1_o, alu_src2_o}, 64'd0);
    rst_i  = 1'b0;
    mon_en = 1;

    run(1'b0, 32'd7, 32'd6);
    run(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(1'b1, 32'd100, 32'd7);
    run(1'b1, 32'h8000_0000, 32'd3);
    run(1'b1, 32'd5, 32'd9);
    run(1'b1, 32'd1234, 32'd0);
    run(1'b1, 32'hFFFF_FFFF, 32'd1);
    run(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Start pulsed mid-computation must be ignored
    issue(1'b0, 32'd123456, 32'd789, acc);
    while (edge_cnt < acc + 10) @(negedge clk_i);
    start_i = 1'b1;
    op_i    = 1'b1;
    src1_i  = 32'd55;
    src2_i  = 32'd0;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_idle();

    // Start presented only during the DONE cycle must be ignored
    issue(1'b1, 32'd1000, 32'd33, acc);
    while (edge_cnt < acc + DATA_W) @(negedge clk_i);
    start_i = 1'b1;
    op_i    = 1'b0;
    src1_i  = 32'd9;
    src2_i  = 32'd9;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk_i);

    // Reset mid-MULTU aborts without a done pulse
    issue(1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D, acc);
    while (edge_cnt < acc + 16) @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    q.delete();
    @(negedge clk_i);
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_done", 64'(done_o), 64'd0);
    chk("abort_hilo", {hi_o, lo_o}, 64'd0);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    run(1'b0, 32'd12345, 32'd6789);

    for (int i = 0; i < 40; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = $urandom;
      sel = $urandom_range(0, 7);
      rb  = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 15)) : $urandom;
      if (sel == 2) ra = 32'($urandom_range(0, 255));
      run(rop, ra, rb);
    end

    repeat (3) @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
